// File: rtl/smem_fill_ctrl.sv
// Fill controller: drives the SMEM row writer to fill a contiguous row range with generated patterns.
// Optional abort support (abort/aborted ports) is enabled by defining SMEM_FILL_ABORT_EN.

module smem_fill_ctrl #(
    parameter int DW         = 512,
    parameter int DONE_GUARD = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cmd_start,
    input  logic [31:0]     cmd_first_row,
    input  logic [31:0]     cmd_row_count,
    input  logic [1:0]      cmd_mode,
    input  logic [31:0]     cmd_seed,
    output logic            busy,
    output logic            complete,
    output logic [31:0]     rows_issued,
    output logic [DW-1:0]   smem_data0,
    output logic [DW-1:0]   smem_data1,
    output logic [DW-1:0]   smem_data2,
    output logic [DW-1:0]   smem_data3,
    output logic [31:0]     row_index,
    output logic            start,
    input  logic            writer_ready,
    input  logic            writer_done
`ifdef SMEM_FILL_ABORT_EN
    ,
    input  logic            abort,
    output logic            aborted
`endif
);

    // A row is 64 words split over four segments; DW=512 gives 16 words per segment.
    localparam int WPS = DW / 32;
    localparam int NW  = 4 * WPS;
    localparam int GW  = $clog2(DONE_GUARD + 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_ACCEPT,
        GUARD,
        DRAIN
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     first_row_q;
    logic [31:0]     row_count_q;
    logic [31:0]     seed_q;
    logic [1:0]      mode_q;
    logic [GW-1:0]   guard_q;
    logic            abort_in;
    logic            abort_hit;
    logic            abort_pend_q;
    logic [31:0]     next_row;
    logic [4*DW-1:0] fill_data;

`ifdef SMEM_FILL_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    // Abort only counts where it can still prevent a start; a start in the same cycle wins.
    assign abort_hit = abort_in && ((state_q == LOAD) ||
                                    (state_q == ISSUE && !writer_ready) ||
                                    (state_q == WAIT_ACCEPT));

    // Pattern for the row about to be loaded; word k sits at bits [k*32 +: 32].
    always_comb begin
        next_row  = first_row_q + rows_issued;
        fill_data = '0;
        for (int k = 0; k < NW; k++) begin
            case (mode_q)
                2'd0:    fill_data[k*32 +: 32] = seed_q;
                2'd1:    fill_data[k*32 +: 32] = seed_q + (rows_issued << 6) + 32'(k);
                2'd2:    fill_data[k*32 +: 32] = next_row;
                default: fill_data[k*32 +: 32] = (k % 2 == 1) ? ~seed_q : seed_q;
            endcase
        end
    end

    // NOTE: every combinational output gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    state_d = (cmd_row_count == 32'd0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                state_d = abort_in ? GUARD : ISSUE;
            end
            ISSUE: begin
                if (writer_ready) begin
                    start   = 1'b1;
                    state_d = WAIT_ACCEPT;
                end else if (abort_in) begin
                    state_d = GUARD;
                end
            end
            WAIT_ACCEPT: begin
                if (writer_ready) begin
                    if (abort_in || abort_pend_q || rows_issued == row_count_q) begin
                        state_d = GUARD;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            GUARD: begin
                if (guard_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (writer_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: the wide data registers are reset too, because the writer-facing outputs must read zero after reset.
            state_q      <= IDLE;
            busy         <= 1'b0;
            complete     <= 1'b0;
            rows_issued  <= 32'd0;
            row_index    <= 32'd0;
            smem_data0   <= '0;
            smem_data1   <= '0;
            smem_data2   <= '0;
            smem_data3   <= '0;
            first_row_q  <= 32'd0;
            row_count_q  <= 32'd0;
            seed_q       <= 32'd0;
            mode_q       <= 2'd0;
            guard_q      <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            complete <= 1'b0;

            if (state_q == IDLE && cmd_start) begin
                first_row_q  <= cmd_first_row;
                row_count_q  <= cmd_row_count;
                mode_q       <= cmd_mode;
                seed_q       <= cmd_seed;
                rows_issued  <= 32'd0;
                busy         <= 1'b1;
                abort_pend_q <= 1'b0;
            end

            // Data and row index change only here; the writer reads them live while emitting.
            if (state_q == LOAD && !abort_in) begin
                row_index  <= next_row;
                smem_data0 <= fill_data[0*DW +: DW];
                smem_data1 <= fill_data[1*DW +: DW];
                smem_data2 <= fill_data[2*DW +: DW];
                smem_data3 <= fill_data[3*DW +: DW];
            end

            if (start) begin
                rows_issued <= rows_issued + 32'd1;
            end

            if (state_d == GUARD && state_q != GUARD) begin
                guard_q <= GW'(DONE_GUARD);
            end else if (state_q == GUARD && guard_q != '0) begin
                guard_q <= guard_q - GW'(1);
            end

            if (abort_hit) begin
                abort_pend_q <= 1'b1;
            end

            if (state_q == DRAIN && writer_done) begin
                complete <= 1'b1;
                busy     <= 1'b0;
            end
        end
    end

`ifdef SMEM_FILL_ABORT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            aborted <= 1'b0;
        end else if (state_q == IDLE && cmd_start) begin
            aborted <= 1'b0;
        end else if (state_q == DRAIN && writer_done && abort_pend_q) begin
            aborted <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/smem_fill_ctrl.md
Name: smem_fill_ctrl

Overview:
- Sequences the SMEM row writer to fill a contiguous range of SMEM rows with generated test patterns.
- Takes a command (first row, row count, pattern mode, seed) and builds each 256-byte row as four DW-bit segments.
- Issues one start per row to the row writer, then waits until the writer reports all rows flushed to the sensor-chip SMEM.
- Sits between the register/command layer and the row writer, on the same clk domain as the writer's input side.

Parameters:
- DW, 512, width of each smem_data segment; must be 512 (4 segments x 16 words = 64 words/row).
- DONE_GUARD, 8, clk cycles to ignore writer_done after the final start; covers writer_done synchronizer latency.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  synchronous, active-low reset.
- cmd_start  in  1  one-cycle strobe; latches cmd_* when idle.
- cmd_first_row  in  32  first SMEM row index.
- cmd_row_count  in  32  number of rows to write.
- cmd_mode  in  2  pattern select.
- cmd_seed  in  32  pattern seed.
- busy  out  1  high from command accept until complete.
- complete  out  1  one-cycle pulse when fill finished and SMEM flushed.
- rows_issued  out  32  rows started in current/last command.
- smem_data0..smem_data3  out  DW each  row data to writer; word k of row = segment k[5:4], bits [k[3:0]*32 +: 32].
- row_index  out  32  row index to writer.
- start  out  1  start strobe to writer.
- writer_ready  in  1  writer ready.
- writer_done  in  1  writer idle and flushed.

Behaviour:
- Reset: state IDLE; busy=0, complete=0, start=0, rows_issued=0, row_index=0, smem_data0..3=0. Reset mid-fill abandons the fill with no complete pulse.
- States: IDLE, LOAD, ISSUE, WAIT_ACCEPT, GUARD, DRAIN.
- IDLE:
  - cmd_start=1 latches all cmd_* fields, clears rows_issued, sets busy.
  - If cmd_row_count==0, go to DRAIN (no start is issued). Otherwise go to LOAD.
  - cmd_start outside IDLE is ignored.
- LOAD (1 cycle):
  - Register row_index = first_row + rows_issued, mod 2^32; wrap past 0xFFFFFFFF is legal.
  - Register all 64 pattern words into smem_data0..3. Go to ISSUE.
- ISSUE:
  - start = (state==ISSUE) & writer_ready, combinational.
  - When start=1: rows_issued += 1 and go to WAIT_ACCEPT.
  - Holds indefinitely while writer_ready=0.
- WAIT_ACCEPT:
  - smem_data0..3 and row_index stay frozen, because the writer reads them live while emitting.
  - When writer_ready=1: if rows_issued != row_count go to LOAD; otherwise load the guard counter with DONE_GUARD and go to GUARD.
- GUARD: decrement the counter each cycle; at 0 go to DRAIN. writer_done is ignored here.
- DRAIN: when writer_done=1, pulse complete for 1 cycle, clear busy in the same cycle, go to IDLE.
- Latency: cmd_start sampled at edge t gives the earliest start at cycle t+2. Consecutive rows are at least 2 cycles apart after writer_ready returns.
- Patterns (row offset r = rows_issued at LOAD, word k = 0..63, all arithmetic mod 2^32):
  - mode 0: seed.
  - mode 1: seed + r*64 + k.
  - mode 2: row_index.
  - mode 3: seed if k even, ~seed if k odd.
- busy=1 from the cycle after cmd_start through the complete cycle. rows_issued holds its final value in IDLE.

Optional Feature:
- Macro: SMEM_FILL_ABORT_EN.
- Defined:
  - Adds input abort (1) and output aborted (1).
  - abort=1 in LOAD or ISSUE, with start not asserted that cycle, goes straight to GUARD; no further starts are issued.
  - abort in WAIT_ACCEPT takes effect once writer_ready=1 (the current row always completes).
  - complete pulses after drain as usual; aborted is set with complete and cleared on the next accepted cmd_start.
  - abort in IDLE, GUARD or DRAIN has no effect.
- Undefined: no abort/aborted ports, and every fill runs to row_count.

Test Plan:
- first_row=0x10, count=3, mode 1, seed=0x1000, writer model always ready -> three starts with row_index 0x10, 0x11, 0x12. Row 2 word 5 = 0x1085. complete pulses once after writer_done and after at least 8 guard cycles; rows_issued=3.
- count=0 -> no start; busy high 1 cycle; complete pulses 2 cycles after cmd_start.
- first_row=0xFFFFFFFF, count=2, mode 2 -> row_index 0xFFFFFFFF then 0x00000000. Every data word equals its row_index.
- Mode 3, seed=0xA5A5A5A5, writer_ready held low 20 cycles -> start stays 0 until ready. smem_data0 word0=0xA5A5A5A5, word1=0x5A5A5A5A. Data is stable every cycle between start and ready returning.
- cmd_start re-pulsed mid-fill with different fields -> ignored; original fill completes unchanged. resetn=0 during WAIT_ACCEPT -> all outputs 0 next cycle, no complete pulse.
- (SMEM_FILL_ABORT_EN) count=10, abort asserted during row 4 WAIT_ACCEPT -> rows_issued=4; complete and aborted=1 after writer_done.
